// File: rtl/spi_master_reader_pkg.sv
// freq_spi_pkg: word sizes, register-select codes and FSM states shared by spi_master_reader.
package freq_spi_pkg;
  localparam int DATA_BITS = 40;
  localparam int CMD_BITS = 8;
  localparam logic [1:0] SEL_COUNTER_NOT = 2'd0;
  localparam logic [1:0] SEL_NX = 2'd1;
  localparam logic [1:0] SEL_NS = 2'd2;
  localparam logic [1:0] SEL_BURST = 2'd3;
  typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, HOLD, DONE} state_e;
endpackage

// File: rtl/spi_master_reader_if.sv
// spi_master_reader_if: host request/response handshake of the SPI reader.
// word_idx exists only when BURST_READ_EN is defined.
interface spi_master_reader_if #(parameter int DATA_BITS = freq_spi_pkg::DATA_BITS);
  logic start;
  logic [1:0] sel;
  logic busy;
  logic [DATA_BITS-1:0] rd_data;
  logic valid;
`ifdef BURST_READ_EN
  logic [1:0] word_idx;
  modport master (output start, sel, input busy, rd_data, valid, word_idx);
  modport slave (input start, sel, output busy, rd_data, valid, word_idx);
`else
  modport master (output start, sel, input busy, rd_data, valid);
  modport slave (input start, sel, output busy, rd_data, valid);
`endif
endinterface

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: mode-0 SCLK at clk/(2*CLK_DIV); strobes mark the last clk of the low (rise) and high (fall) phases.
module spi_sclk_gen #(
  parameter int CLK_DIV = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_stb,
  output logic o_fall_stb
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  logic [CW-1:0] r_cnt;
  logic r_sclk;
  logic w_wrap;
  assign w_wrap = i_en && r_cnt == LAST;
  assign o_rise_stb = w_wrap && !r_sclk;
  assign o_fall_stb = w_wrap && r_sclk;
  assign o_sclk = r_sclk;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= (!i_en || w_wrap) ? '0 : r_cnt + 1'b1;
      r_sclk <= i_en && (r_sclk ^ w_wrap);
    end
endmodule

// File: rtl/spi_master_reader.sv
// spi_master_reader: mode-0 SPI master sending {6'b0,sel} then reading one DATA_BITS word MSB first.
// BURST_READ_EN: sel=3 reads three words in a single CS_n frame, each tagged with word_idx.
module spi_master_reader #(
  parameter int CLK_DIV = 3,
  parameter int CMD_BITS = freq_spi_pkg::CMD_BITS,
  parameter int DATA_BITS = freq_spi_pkg::DATA_BITS,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC = 2
) (
  input  logic clk_12MHz,
  input  logic rst,
  spi_master_reader_if.slave host,
  output logic o_SPI_CLK,
  output logic o_SPI_CS,
  output logic o_SPI_MOSI,
  input  logic i_SPI_MISO
);
  import freq_spi_pkg::*;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] CMD_N = BW'(CMD_BITS);
  localparam logic [BW-1:0] DATA_N = BW'(DATA_BITS);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD_CYC - 1);
  state_e r_state, w_next;
  logic [CMD_BITS-1:0] r_cmd;
  logic [DATA_BITS-1:0] r_shift, r_rd_data, w_shift_in;
  logic [BW-1:0] r_bit;
  logic [7:0] r_cnt;
  logic r_valid;
  logic w_en, w_sclk, w_rise, w_fall;
  logic w_word_end, w_last_word, w_burst_frame, w_burst_load, w_single_load;
  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk_12MHz),
    .rst(rst),
    .i_en(w_en),
    .o_sclk(w_sclk),
    .o_rise_stb(w_rise),
    .o_fall_stb(w_fall)
  );
  assign w_shift_in = {r_shift[DATA_BITS-2:0], i_SPI_MISO};
  // r_bit counts SCLK rises, so a word ends on the fall that follows the DATA_BITS-th rise
  assign w_word_end = r_state == DATA && w_fall && r_bit == DATA_N;
`ifdef BURST_READ_EN
  logic r_burst;
  logic [1:0] r_word, r_word_idx;
  assign w_burst_frame = r_burst;
  assign w_last_word = !r_burst || r_word == 2'd2;
  always_ff @(posedge clk_12MHz or posedge rst)
    if (rst) begin
      r_burst <= 1'b0;
      r_word <= '0;
      r_word_idx <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_burst <= host.sel == SEL_BURST;
        r_word <= '0;
      end else if (w_word_end) r_word <= r_word + 1'b1;
      if (w_burst_load) r_word_idx <= r_word;
    end
  assign host.word_idx = r_word_idx;
`else
  assign w_burst_frame = 1'b0;
  assign w_last_word = 1'b1;
`endif
  assign w_burst_load = w_burst_frame && w_word_end;
  assign w_single_load = !w_burst_frame && r_state == HOLD && w_next == DONE;
  always_ff @(posedge clk_12MHz or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = host.start ? SETUP : IDLE;
      SETUP:   w_next = r_cnt == SETUP_LAST ? CMD : SETUP;
      CMD:     w_next = (w_fall && r_bit == CMD_N) ? DATA : CMD;
      DATA:    w_next = (w_word_end && w_last_word) ? HOLD : DATA;
      HOLD:    w_next = r_cnt == HOLD_LAST ? DONE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_12MHz or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_cmd <= '0;
      r_shift <= '0;
      r_rd_data <= '0;
      r_valid <= 1'b0;
    end else begin
      r_cnt <= r_state == w_next ? r_cnt + 1'b1 : '0;
      r_bit <= (r_state != w_next || w_word_end) ? '0 : r_bit + BW'(w_rise);
      r_cmd <= r_state == IDLE ? CMD_BITS'(host.sel) : (r_state == CMD && w_fall) ? r_cmd << 1 : r_cmd;
      if (r_state == DATA && w_fall) r_shift <= w_shift_in;
      if (w_burst_load) r_rd_data <= w_shift_in;
      else if (w_single_load) r_rd_data <= r_shift;
      r_valid <= w_burst_load || w_single_load;
    end
  assign w_en = r_state == CMD || r_state == DATA;
  assign host.busy = r_state != IDLE;
  assign host.valid = r_valid;
  assign host.rd_data = r_rd_data;
  assign o_SPI_CLK = w_sclk;
  assign o_SPI_CS = r_state == IDLE || r_state == DONE;
  assign o_SPI_MOSI = (r_state == SETUP || r_state == CMD) && r_cmd[CMD_BITS-1];
endmodule

// File: tb/tb_spi_master_reader.sv
// tb_spi_master_reader: mode-0 slave model plus frame monitor; checks words, framing and SCLK timing.
`timescale 1ns/1ps
module tb_spi_master_reader;
  localparam int DB = 40;
`ifdef BURST_READ_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, miso = 1'b0;
  logic spi_clk, spi_cs, spi_mosi;
  always #5 clk = ~clk;
  spi_master_reader_if #(.DATA_BITS(DB)) h ();
  spi_master_reader dut (
    .clk_12MHz(clk),
    .rst(rst),
    .host(h),
    .o_SPI_CLK(spi_clk),
    .o_SPI_CS(spi_cs),
    .o_SPI_MOSI(spi_mosi),
    .i_SPI_MISO(miso)
  );
  int n_pass = 0, n_chk = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // slave register file; command 3 streams words 0,1,2 back to back
  logic [DB-1:0] regs [4];
  function automatic logic [DB-1:0] reply(input logic [7:0] c, input int k);
    return (c == 8'd3) ? regs[k] : regs[c[1:0]];
  endfunction
  int s_bits, s_idx;
  logic [7:0] s_cmd;
  logic [DB-1:0] s_word;
  always @(negedge spi_cs) begin
    s_bits = 0;
    s_cmd = '0;
  end
  always @(posedge spi_clk) if (!spi_cs) begin
    if (s_bits < 8) s_cmd = {s_cmd[6:0], spi_mosi};
    s_bits++;
  end
  always @(negedge spi_clk) if (!spi_cs && s_bits >= 8) begin
    s_idx = s_bits - 8;
    s_word = reply(s_cmd, s_idx / DB);
    miso = s_idx < 3 * DB ? s_word[DB - 1 - s_idx % DB] : 1'b0;
  end
  int cs_low, cs_falls, rises, run, hi_min, hi_max, lo_min, lo_max, mosi_bad, n_valid, busy_bad;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_valid = 1'b0, first_lo, after_busy;
  logic [DB-1:0] got_q [$];
  logic [1:0] idx_q [$];
  task automatic clear_mon();
    cs_low = 0; cs_falls = 0; rises = 0; run = 0; mosi_bad = 0; n_valid = 0; busy_bad = 0;
    hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0; after_busy = 1'b1;
    got_q.delete();
    idx_q.delete();
  endtask
  always @(negedge clk) begin
    if (!spi_cs) begin
      cs_low++;
      if (prev_cs) begin
        cs_falls++;
        run = 1;
        first_lo = 1'b1;
      end else begin
        if (spi_clk && spi_mosi !== prev_mosi) mosi_bad++;
        if (spi_clk === prev_sclk) run++;
        else begin
          if (prev_sclk) begin
            hi_min = run < hi_min ? run : hi_min;
            hi_max = run > hi_max ? run : hi_max;
          end else if (!first_lo) begin
            lo_min = run < lo_min ? run : lo_min;
            lo_max = run > lo_max ? run : lo_max;
          end
          if (spi_clk) rises++;
          first_lo = 1'b0;
          run = 1;
        end
      end
    end
    if (h.valid) begin
      n_valid++;
      got_q.push_back(h.rd_data);
      if (!h.busy) busy_bad++;
`ifdef BURST_READ_EN
      idx_q.push_back(h.word_idx);
`endif
    end
    if (prev_valid) after_busy = h.busy;
    prev_cs = spi_cs;
    prev_sclk = spi_clk;
    prev_mosi = spi_mosi;
    prev_valid = h.valid;
  end
  // mode 1: extra start 10 cycles into the frame; mode 2: start in the valid cycle
  task automatic frame(input logic [1:0] s, input int mode);
    int n, seen, budget;
    logic [7:0] c;
    c = {6'b0, s};
    n = (BURST && s == 2'd3) ? 3 : 1;
    clear_mon();
    h.sel = s;
    h.start = 1'b1;
    @(negedge clk);
    h.start = 1'b0;
    h.sel = 2'($urandom);
    if (mode == 1) begin
      repeat (9) @(negedge clk);
      h.start = 1'b1;
      @(negedge clk);
      h.start = 1'b0;
    end
    seen = 0;
    budget = 0;
    while (seen < n && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (h.valid) seen++;
    end
    if (mode == 2) begin
      h.start = 1'b1;
      @(negedge clk);
      h.start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("timeout", 64'(budget < 2000), 64'd1);
    check("cmd_byte", 64'(s_cmd), 64'(c));
    check("n_valid", 64'(n_valid), 64'(n));
    for (int k = 0; k < n; k++) begin
      check("rd_data", k < got_q.size() ? 64'(got_q[k]) : 'x, 64'(reply(c, k)));
      if (BURST) check("word_idx", k < idx_q.size() ? 64'(idx_q[k]) : 'x, 64'(k));
    end
    check("cs_low_cycles", 64'(cs_low), 64'(2 + (8 + DB * n) * 6 + 2));
    check("cs_frames", 64'(cs_falls), 64'd1);
    check("sclk_rises", 64'(rises), 64'(8 + DB * n));
    check("sclk_hi_min", 64'(hi_min), 64'd3);
    check("sclk_hi_max", 64'(hi_max), 64'd3);
    check("sclk_lo_min", 64'(lo_min), 64'd3);
    check("sclk_lo_max", 64'(lo_max), 64'd3);
    check("mosi_stable", 64'(mosi_bad), 64'd0);
    check("busy_at_valid", 64'(busy_bad), 64'd0);
    if (n == 1) check("busy_after_valid", 64'(after_busy), 64'd0);
    check("cs_idle", 64'(spi_cs), 64'd1);
    check("rd_data_hold", 64'(h.rd_data), 64'(reply(c, n - 1)));
  endtask
  initial begin
    int budget;
    h.start = 1'b0;
    h.sel = 2'd0;
    regs[0] = 40'h0000000001;
    regs[1] = 40'h0000004455;
    regs[2] = 40'h005456789A;
    regs[3] = 40'hA5A5A5A5A5;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(spi_cs), 64'd1);
    check("rst_sclk", 64'(spi_clk), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd0);
    check("rst_busy", 64'(h.busy), 64'd0);
    check("rst_valid", 64'(h.valid), 64'd0);
    check("rst_data", 64'(h.rd_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    frame(2'd1, 0);
    frame(2'd2, 0);
    frame(2'd0, 0);
    frame(2'd1, 1);
    frame(2'd2, 2);
    // reset while DATA bit 20 is on the wire
    clear_mon();
    h.sel = 2'd1;
    h.start = 1'b1;
    @(negedge clk);
    h.start = 1'b0;
    budget = 0;
    while (s_bits < 8 + 20 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check("rst_reach_bit20", 64'(budget < 1000), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_cs", 64'(spi_cs), 64'd1);
    check("midrst_sclk", 64'(spi_clk), 64'd0);
    check("midrst_mosi", 64'(spi_mosi), 64'd0);
    check("midrst_data", 64'(h.rd_data), 64'd0);
    check("midrst_busy", 64'(h.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("midrst_no_valid", 64'(n_valid), 64'd0);
    check("midrst_cs_idle", 64'(spi_cs), 64'd1);
    frame(2'd0, 0);
    frame(2'd3, 0);
    for (int i = 0; i < 4; i++) regs[i] = {8'($urandom), $urandom()};
    for (int i = 0; i < 5; i++) frame(2'($urandom_range(0, 3)), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
